// File: rtl/allign_sched_pkg.sv
// allign_sched_pkg: shared constants, field bounds and FSM state type for the
// alignment-stage issue scheduler.
// Optional feature macro: ALLIGN_DIFF_SAT_EN (used by allign_exp_diff).
package allign_sched_pkg;

  // Rotation mode codes carried through to the alignment stage
  localparam logic [1:0] MODE_LINEAR     = 2'b00;
  localparam logic [1:0] MODE_CIRCULAR   = 2'b01;
  localparam logic [1:0] MODE_HYPERBOLIC = 2'b11;

  // Idle codes; IDLE_PUT marks a bubble on the alignment bus
  localparam logic [1:0] IDLE_NO     = 2'b00;
  localparam logic [1:0] IDLE_ALLIGN = 2'b01;
  localparam logic [1:0] IDLE_PUT    = 2'b10;

  // Operand layout: sign [35], biased exponent [34:27], mantissa [26:0]
  localparam int OP_W   = 36;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 27;
  localparam int EXP_HI = 34;
  localparam int EXP_LO = 27;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Extract the biased exponent field of an operand
  function automatic logic [EXP_W-1:0] exp_of(input logic [OP_W-1:0] op);
    return op[EXP_HI:EXP_LO];
  endfunction

endpackage

// File: rtl/allign_exp_diff.sv
// allign_exp_diff: absolute difference of the biased exponents of two operands.
// Latency: combinational. Backpressure: none.
// ALLIGN_DIFF_SAT_EN defined: result clamps to the mantissa width (27).
module allign_exp_diff
  import allign_sched_pkg::*;
(
  input  logic [OP_W-1:0]  i_cout,
  input  logic [OP_W-1:0]  i_zout,
  output logic [EXP_W-1:0] o_diff
);

  logic [EXP_W:0]   w_sub;
  logic [EXP_W-1:0] w_abs;

  // 9-bit subtract keeps the borrow; negate the low byte when it is set
  always_comb begin
    w_sub = {1'b0, exp_of(i_cout)} - {1'b0, exp_of(i_zout)};
    w_abs = w_sub[EXP_W] ? (~w_sub[EXP_W-1:0] + 8'd1) : w_sub[EXP_W-1:0];
  end

`ifdef ALLIGN_DIFF_SAT_EN
  // Shifts beyond the mantissa width flush everything, so clamp there
  always_comb begin
    o_diff = (w_abs > 8'(MANT_W)) ? 8'(MANT_W) : w_abs;
  end
`else
  // Raw absolute difference, full 0..255 range
  always_comb begin
    o_diff = w_abs;
  end
`endif

endmodule

// File: rtl/allign_sched.sv
// allign_sched: round-robin issue of two requesters onto the HCORDIC alignment bus.
// Latency: one cycle from handshake edge to registered output bus.
// Backpressure: req_ready drops with no credits or while draining; bubbles carry put_idle.
// Optional feature macro: ALLIGN_DIFF_SAT_EN (saturating exponent difference).
module allign_sched
  import allign_sched_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [3:0]  i_req_idle,
  input  logic [71:0] i_req_cout,
  input  logic [71:0] i_req_zout,
  input  logic [63:0] i_req_sout,
  input  logic [3:0]  i_req_mode,
  input  logic [1:0]  i_req_op,
  input  logic [1:0]  i_req_natlog,
  input  logic [15:0] i_req_tag,
  input  logic        i_credit_return,
  input  logic        i_flush,
  output logic [1:0]  o_idle_Allign,
  output logic [35:0] o_cout_Allign,
  output logic [35:0] o_zout_Allign,
  output logic [31:0] o_sout_Allign,
  output logic [1:0]  o_modeout_Allign,
  output logic        o_operationout_Allign,
  output logic        o_NatLogFlagout_Allign,
  output logic [7:0]  o_difference_Allign,
  output logic [7:0]  o_InsTag_Allign,
  output logic        o_grant_id,
  output logic        o_flush_done,
  output logic        o_credit_err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

  state_t           r_state;
  logic [CNT_W-1:0] r_credits;
  logic             r_last_grant;

  logic             w_grant;
  logic             w_issue;
  logic             w_full;
  logic [1:0]       w_idle;
  logic [35:0]      w_cout;
  logic [35:0]      w_zout;
  logic [31:0]      w_sout;
  logic [1:0]       w_mode;
  logic             w_op;
  logic             w_natlog;
  logic [7:0]       w_tag;
  logic [7:0]       w_diff;

  // Arbitration: a lone requester wins; on contention alternate away from the last winner
  always_comb begin
    w_grant = 1'b0;
    case (i_req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = 1'b0;
    endcase
    o_req_ready = 2'b00;
    if (r_state == RUN && r_credits != '0 && i_req_valid[w_grant]) begin
      o_req_ready[w_grant] = 1'b1;
    end
    w_issue = |o_req_ready;
    w_full  = (r_credits == FULL);
  end

  // Select the granted requester's fields
  always_comb begin
    w_idle   = w_grant ? i_req_idle[3:2]    : i_req_idle[1:0];
    w_cout   = w_grant ? i_req_cout[71:36]  : i_req_cout[35:0];
    w_zout   = w_grant ? i_req_zout[71:36]  : i_req_zout[35:0];
    w_sout   = w_grant ? i_req_sout[63:32]  : i_req_sout[31:0];
    w_mode   = w_grant ? i_req_mode[3:2]    : i_req_mode[1:0];
    w_op     = w_grant ? i_req_op[1]        : i_req_op[0];
    w_natlog = w_grant ? i_req_natlog[1]    : i_req_natlog[0];
    w_tag    = w_grant ? i_req_tag[15:8]    : i_req_tag[7:0];
  end

  allign_exp_diff u_exp_diff (
    .i_cout (w_cout),
    .i_zout (w_zout),
    .o_diff (w_diff)
  );

  // Credit accounting; a surplus return is dropped and flagged stickily
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_credits    <= FULL;
      o_credit_err <= 1'b0;
    end else if (w_issue && !i_credit_return) begin
      r_credits <= r_credits - CNT_W'(1);
    end else if (!w_issue && i_credit_return) begin
      if (w_full) begin
        o_credit_err <= 1'b1;
      end else begin
        r_credits <= r_credits + CNT_W'(1);
      end
    end
  end

  // Flush/drain FSM: stop granting until every credit is home, then pulse done
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= RUN;
      o_flush_done <= 1'b0;
    end else begin
      o_flush_done <= 1'b0;
      case (r_state)
        RUN: begin
          if (i_flush) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_full) begin
            o_flush_done <= 1'b1;
            r_state      <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Output bus: load on issue, otherwise bubble with data held
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_idle_Allign          <= IDLE_PUT;
      o_cout_Allign          <= '0;
      o_zout_Allign          <= '0;
      o_sout_Allign          <= '0;
      o_modeout_Allign       <= '0;
      o_operationout_Allign  <= 1'b0;
      o_NatLogFlagout_Allign <= 1'b0;
      o_difference_Allign    <= '0;
      o_InsTag_Allign        <= '0;
      o_grant_id             <= 1'b0;
      r_last_grant           <= 1'b1;
    end else if (w_issue) begin
      o_idle_Allign          <= w_idle;
      o_cout_Allign          <= w_cout;
      o_zout_Allign          <= w_zout;
      o_sout_Allign          <= w_sout;
      o_modeout_Allign       <= w_mode;
      o_operationout_Allign  <= w_op;
      o_NatLogFlagout_Allign <= w_natlog;
      o_difference_Allign    <= w_diff;
      o_InsTag_Allign        <= w_tag;
      o_grant_id             <= w_grant;
      r_last_grant           <= w_grant;
    end else begin
      o_idle_Allign <= IDLE_PUT;
    end
  end

endmodule

// File: doc/allign_sched.md
# allign_sched

Round-robin issue scheduler that shares the single HCORDIC alignment stage between two operand requesters. It arbitrates between the requesters, computes the exponent difference the alignment stage needs, and drives the stage's input bus one registered operation per cycle. A credit counter and a flush/drain state machine bound the number of operations in flight behind it.

## Interface
- CREDITS, 4: maximum operations in flight between issue and credit return (1..7)
- CNT_W, 3: credit counter width
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester valid; bit i = requester i
- req_ready  out  2  per-requester ready, combinational
- req_idle  in  4  per-requester idle code, [2i+1:2i]; legal values 2'b00 no_idle, 2'b01 allign_idle
- req_cout, req_zout  in  72 each  per-requester 36-bit operands, [36i+35:36i]; sign [35], biased exponent [34:27], mantissa [26:0]
- req_sout  in  64  per-requester 32-bit s value
- req_mode  in  4  per-requester mode (00 linear, 01 circular, 11 hyperbolic)
- req_op, req_natlog  in  2 each  per-requester operation and NatLog flags
- req_tag  in  16  per-requester 8-bit instruction tag
- credit_return  in  1  one-cycle pulse; one operation has left the pipeline
- flush  in  1  one-cycle pulse; request drain
- idle_Allign  out  2  to alignment stage; 2'b10 (put_idle) on bubbles
- cout_Allign, zout_Allign  out  36  operands
- sout_Allign  out  32
- modeout_Allign  out  2
- operationout_Allign, NatLogFlagout_Allign  out  1
- difference_Allign  out  8  exponent difference
- InsTag_Allign  out  8
- grant_id  out  1  requester of the current issued operation
- flush_done  out  1  one-cycle pulse when drain completes
- credit_err  out  1  sticky; credit_return received with counter at CREDITS

## Operation
- States: RUN, DRAIN. Reset -> RUN.
- Grant, combinational: if only one req_valid is set, that requester; if both, the requester not equal to last_grant.
- req_ready[i] = (state==RUN) && (credits!=0) && grant==i && req_valid[i]. At most one bit is ever set.
- Issue = any req_ready bit set. On issue: register the granted requester's fields onto the output bus, set grant_id and last_grant, and decrement credits.
- No issue: idle_Allign = 2'b10. All other outputs hold their previous values.
- difference_Allign = |cexp − zexp| on the unsigned 8-bit biased exponent fields [34:27], computed via a 9-bit subtraction.
- credit_return: increments credits. Issue and return in the same cycle leave credits unchanged. A return while credits==CREDITS with no issue in that cycle is dropped and sets credit_err. credit_err clears only on reset.
- flush in RUN: move to DRAIN at the next edge. The issue in the flush cycle is still allowed.
- DRAIN: no grants. When credits==CREDITS, pulse flush_done for one cycle and return to RUN.
- flush while in DRAIN: ignored.
- Asynchronous reset mid-operation: in-flight state is lost, and all credits are restored to CREDITS.
- Reset values: idle_Allign 2'b10; all other data outputs 0; grant_id 0; last_grant 1, so requester 0 wins first; credits CREDITS; flush_done 0; credit_err 0; state RUN.

## Timing
- Handshake completes at rising edge N when req_valid[i] && req_ready[i].
- The operation is on the output bus from edge N until edge N+1, where the alignment stage samples it. Scheduler latency is one cycle.
- Peak throughput is one issue per cycle while credits remain.
- With CREDITS outstanding, req_ready is low until the cycle after the credit_return edge.
- flush_done rises at the edge after the last credit returns. If credits is already full, it rises one cycle after the DRAIN entry edge.

## Configuration
- ALLIGN_DIFF_SAT_EN defined: difference_Allign saturates to 8'd27 (the mantissa width) when |Δexp| > 27.
- ALLIGN_DIFF_SAT_EN undefined: difference_Allign carries the raw 8-bit absolute difference (0..255).

## Structure
- Package allign_sched_pkg holds:
  - mode constants (00, 01, 11) and idle constants (no_idle 00, allign_idle 01, put_idle 10);
  - MANT_W = 27 and the exponent field bounds 34/27;
  - state enum {RUN, DRAIN}.
- Sub-module allign_exp_diff: purely combinational. Takes two 36-bit operands and produces the 8-bit absolute exponent difference, with saturation under the macro.

## Test plan
- Both requesters valid for 4 cycles, credit_return every cycle -> grants 0,1,0,1; one handshake per cycle; idle_Allign 00 on each issue.
- Requester 0 cexp 0x90, zexp 0x80 -> difference 16. cexp 0x80, zexp 0xC0 -> 64 without the macro, 27 with ALLIGN_DIFF_SAT_EN.
- Requester 0 valid continuously, no returns -> 4 issues, then req_ready low and idle_Allign 10. One credit_return -> exactly one more issue.
- 3 outstanding, flush pulse -> no grants. 3 returns -> flush_done pulses one cycle after the last return edge, then granting resumes.
- credit_return while credits==4 -> credit_err=1 and credits stay 4. Issue plus return in the same cycle -> credits unchanged.
- reset_n low mid-stream -> idle_Allign 10, credits 4, requester 0 granted first after release.
